// File: rtl/console_tx_if.sv
// Bus bundle between the core's data-memory write port and the console
// transmitter. The core side is the master; the console is the slave.
interface console_tx_if;
  logic        memwrite;
  logic [31:0] dataadr;
  logic [31:0] writedata;
  logic        tx;
  logic        tx_busy;
  logic        fifo_full;
  logic        fifo_empty;
  logic        overflow;

  modport master (
    output memwrite, dataadr, writedata,
    input  tx, tx_busy, fifo_full, fifo_empty, overflow
  );

  modport slave (
    input  memwrite, dataadr, writedata,
    output tx, tx_busy, fifo_full, fifo_empty, overflow
  );
endinterface

// File: rtl/console_tx.sv
// Memory-mapped console output: stores to CONSOLE_ADDR are queued in a
// byte FIFO and shifted out LSB first on an 8N1 UART line.
module console_tx #(
  parameter logic [31:0] CONSOLE_ADDR = 32'h0000_FFFC,
  parameter int unsigned DEPTH        = 16,
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input logic         clk,
  input logic         reset,
  console_tx_if.slave bus
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned TMR_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);
  localparam logic [TMR_W-1:0] LAST_TICK  = TMR_W'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t           state_q, state_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic [2:0]       bitIdx_q, bitIdx_d;
  logic [7:0]       shift_q, shift_d;
  logic             tx_q, tx_d;

  logic [7:0]       mem_q [DEPTH];
  logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
  logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             overflow_q, overflow_d;

  logic pushReq;
  logic pushOk;
  logic pop;
  logic fifoFull;
  logic fifoEmpty;
  logic unusedUpper;

  // Only the low byte of a store reaches the line; the rest is discarded.
  assign unusedUpper = ^bus.writedata[31:8];

  assign fifoFull  = (count_q == FULL_COUNT);
  assign fifoEmpty = (count_q == '0);

  // The serializer takes the head byte whenever it is idle and data waits;
  // that pop frees a slot on the same edge, so a push into a full FIFO
  // still lands when it coincides with a pop.
  assign pop     = (state_q == IDLE) && !fifoEmpty;
  assign pushReq = bus.memwrite && (bus.dataadr == CONSOLE_ADDR);
  assign pushOk  = pushReq && (!fifoFull || pop);

  // FIFO bookkeeping: pointers, occupancy and the sticky drop flag.
  always_comb begin
    wrPtr_d    = wrPtr_q;
    rdPtr_d    = rdPtr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (pushOk) begin
      wrPtr_d = wrPtr_q + PTR_W'(1);
    end
    if (pop) begin
      rdPtr_d = rdPtr_q + PTR_W'(1);
    end
    if (pushOk && !pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (!pushOk && pop) begin
      count_d = count_q - CNT_W'(1);
    end
    if (pushReq && !pushOk) begin
      overflow_d = 1'b1;
    end
  end

  // FIFO storage has no reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (reset && pushOk) begin
      mem_q[wrPtr_q] <= bus.writedata[7:0];
    end
  end

  // FIFO control registers, flushed by reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wrPtr_q    <= '0;
      rdPtr_q    <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wrPtr_q    <= wrPtr_d;
      rdPtr_q    <= rdPtr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Serializer next state; tx is derived from the next state so the line
  // comes straight out of a flop and cannot glitch.
  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    bitIdx_d = bitIdx_q;
    shift_d  = shift_q;
    unique case (state_q)
      IDLE: begin
        if (pop) begin
          shift_d = mem_q[rdPtr_q];
          timer_d = '0;
          state_d = START;
        end
      end
      START: begin
        if (timer_q == LAST_TICK) begin
          timer_d  = '0;
          bitIdx_d = '0;
          state_d  = DATA;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      DATA: begin
        if (timer_q == LAST_TICK) begin
          timer_d = '0;
          shift_d = shift_q >> 1;
          if (bitIdx_q == 3'd7) begin
            state_d = STOP;
          end else begin
            bitIdx_d = bitIdx_q + 3'd1;
          end
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      STOP: begin
        if (timer_q == LAST_TICK) begin
          timer_d = '0;
          state_d = IDLE;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    unique case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  // Serializer registers; reset aborts any frame in flight.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      timer_q  <= '0;
      bitIdx_q <= '0;
      shift_q  <= '0;
      tx_q     <= 1'b1;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      bitIdx_q <= bitIdx_d;
      shift_q  <= shift_d;
      tx_q     <= tx_d;
    end
  end

  assign bus.tx         = tx_q;
  assign bus.tx_busy    = (state_q != IDLE);
  assign bus.fifo_full  = fifoFull;
  assign bus.fifo_empty = fifoEmpty;
  assign bus.overflow   = overflow_q;

endmodule

// File: doc/console_tx.md
# console_tx

Memory-mapped console output for the RV32I cores. It sits directly downstream of the core's data-memory write port, in parallel with data memory. Stores to the console address are captured into a byte FIFO and serialised onto a single 8N1 UART line. This gives the console-print path a real hardware sink for FPGA builds, in addition to the simulation-only character dump.

## Interface
Parameters:
- CONSOLE_ADDR, 32'h0000_FFFC, byte address decoded as the console data register.
- DEPTH, 16, FIFO depth in bytes; must be a power of 2, minimum 2.
- CLKS_PER_BIT, 16, clock cycles per UART bit; minimum 2.

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-low reset (0 = reset asserted).
- memwrite  in  1  core store strobe.
- dataadr  in  32  core data address.
- writedata  in  32  core store data; only bits [7:0] are used.
- tx  out  1  UART serial line; idles high.
- tx_busy  out  1  serializer is not in IDLE.
- fifo_full  out  1  FIFO holds DEPTH bytes.
- fifo_empty  out  1  FIFO holds 0 bytes.
- overflow  out  1  sticky flag: a console store was dropped.

## Operation
- Push condition: memwrite && dataadr == CONSOLE_ADDR, checked on every edge with reset=1. Full 32-bit address compare; no byte-lane decoding. writedata[31:8] is ignored.
- FIFO:
  - Circular buffer with rd_ptr/wr_ptr of log2(DEPTH) bits that wrap modulo DEPTH.
  - Occupancy count of log2(DEPTH)+1 bits.
  - fifo_full = (count == DEPTH); fifo_empty = (count == 0), both combinational from count.
- Simultaneous push and pop: a pop frees a slot in the same cycle, so a push while full is accepted if a pop happens that edge; count is unchanged.
- Push while full with no pop: byte dropped, FIFO unchanged, overflow set to 1. overflow is cleared only by reset.
- Serializer FSM states: IDLE, START, DATA, STOP. The FSM uses a bit-timer of 0..CLKS_PER_BIT-1, a bit index of 0..7 and an 8-bit shift register.
  - IDLE: tx=1. If !fifo_empty, pop the head byte into the shift register, clear the timer and go to START.
  - START: tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: tx=shift[0], LSB first. Each bit lasts CLKS_PER_BIT cycles, then shift right. After bit 7, go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles, then go to IDLE.
- tx is a registered output and does not glitch.
- tx_busy = (state != IDLE).

## Timing
- Reset values, one edge after reset=0 is sampled:
  - tx=1, tx_busy=0, fifo_full=0, fifo_empty=1, overflow=0.
  - Pointers and count are 0; state is IDLE.
  - FIFO contents are don't-care.
- Reset mid-frame: the frame is aborted. tx=1 at the next edge, FIFO flushed. Pushes are ignored while reset=0.
- Push latency: a store sampled at edge k makes fifo_empty=0 after edge k.
- Pop timing: with the serializer in IDLE, pop happens at edge k+1 and tx falls after edge k+1. Store-to-start-bit is 2 edges.
- Frame length: 10*CLKS_PER_BIT cycles from the start-bit edge to the end of the stop bit.
- Inter-frame gap: exactly 1 IDLE cycle of tx=1 between back-to-back frames.
- Sustained throughput: 1 byte per 10*CLKS_PER_BIT+1 cycles. A core storing faster than that fills the FIFO; overflow indicates loss.
- The pop in IDLE and a push in the same cycle are treated as simultaneous, per the rule above.

## Test plan
- Single byte, CLKS_PER_BIT=4: store 32'h1234_5641 to 0xFFFC.
  - Required tx after the start edge: 4 cycles low, then bits 1,0,0,0,0,0,1,0 for 4 cycles each, then 4 cycles high.
  - tx_busy high for exactly 40 cycles; upper data bits have no effect.
- Address filter: stores to 0xFFF8, 0x1FFFC and 0x0 with memwrite=1, plus 0xFFFC with memwrite=0.
  - Required: fifo_empty stays 1 and tx stays 1 throughout.
- Back-to-back: store "Hi\n" (0x48, 0x69, 0x0A) on 3 consecutive cycles.
  - Required: three frames decoded in order, each separated by exactly 1 idle cycle; fifo_empty=1 after the third pop.
- Overflow, DEPTH=16: 18 consecutive stores starting while the serializer is IDLE.
  - First store is popped, the next 16 fill the FIFO, the 18th is dropped.
  - Required: fifo_full=1 and overflow=1; exactly 17 bytes are transmitted, the 18th is absent.
- Full with simultaneous pop: with the FIFO full, time a store to the edge where IDLE pops.
  - Required: the byte is accepted, count stays 16, overflow stays 0.
- Reset mid-frame: assert reset=0 for 1 cycle during DATA bit 3 with 5 bytes queued.
  - Required: after the next edge tx=1, tx_busy=0, fifo_empty=1, overflow=0; no further frames are sent.
